// File: rtl/welcome_menu_ctrl.sv
// Welcome-screen menu controller: key debounce, menu FSM, start pulse and cursor blink.
// Optional ACK auto-return timeout is built when ACK_TIMEOUT_EN is defined.
module welcome_menu_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [5:0]  BLINK_FRAMES    = 6'd30,
  parameter logic [9:0]  ACK_FRAMES      = 10'd600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       key_esc,
  input  logic       frame_tick,
  input  logic       game_over,
  output logic [1:0] state,
  output logic       in_game,
  output logic       start_game,
  output logic       cursor_blink
);

  localparam int unsigned NKEYS = 4;
  localparam int unsigned DBW   = 16;
  localparam int unsigned BLW   = 6;
  localparam int unsigned KUP   = 0;
  localparam int unsigned KDOWN = 1;
  localparam int unsigned KENT  = 2;
  localparam int unsigned KESC  = 3;

  typedef enum logic [1:0] {
    S_CHOICE1 = 2'd0,
    S_CHOICE2 = 2'd1,
    S_ACK     = 2'd2,
    S_GAME    = 2'd3
  } fsm_e;

  logic [NKEYS-1:0] raw_c;
  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] db_q, db_d, db_prev_q;
  logic [DBW-1:0]   cnt_q [NKEYS];
  logic [DBW-1:0]   cnt_d [NKEYS];
  logic [NKEYS-1:0] press_c;

  fsm_e             fsm_q, fsm_d;
  logic             trans_c;
  logic             timeout_c;
  logic [BLW-1:0]   blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;
  logic [1:0]       state_q, state_d;
  logic             in_game_q, in_game_d;
  logic             start_q, start_d;

  assign raw_c = {key_esc, key_enter, key_down, key_up};

  // Debounce: counter clears whenever the synced level matches the accepted level
  always_comb begin
    db_d = db_q;
    for (int k = 0; k < NKEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync2_q[k] == db_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] >= DEBOUNCE_CYCLES - 16'd1) begin
        cnt_d[k] = '0;
        db_d[k]  = sync2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q   <= raw_c;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign press_c = db_q & ~db_prev_q;

`ifdef ACK_TIMEOUT_EN
  logic [9:0] ack_cnt_q, ack_cnt_d;

  assign timeout_c = (ack_cnt_q >= ACK_FRAMES);

  // Frame count while sitting in ACK; cleared outside ACK and on any transition
  always_comb begin
    ack_cnt_d = ack_cnt_q;
    if (fsm_q != S_ACK || trans_c) begin
      ack_cnt_d = '0;
    end else if (frame_tick && ack_cnt_q < ACK_FRAMES) begin
      ack_cnt_d = ack_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_cnt_q <= '0;
    else        ack_cnt_q <= ack_cnt_d;
  end
`else
  logic unused_ack_frames_c;
  assign unused_ack_frames_c = ^ACK_FRAMES;
  assign timeout_c           = 1'b0;
`endif

  // Menu FSM next state; enter beats esc beats up/down
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_CHOICE1: begin
        if (press_c[KENT])                          fsm_d = S_GAME;
        else if (press_c[KESC])                     fsm_d = S_CHOICE1;
        else if (press_c[KUP] ^ press_c[KDOWN])     fsm_d = S_CHOICE2;
      end
      S_CHOICE2: begin
        if (press_c[KENT])                          fsm_d = S_ACK;
        else if (press_c[KESC])                     fsm_d = S_CHOICE2;
        else if (press_c[KUP] ^ press_c[KDOWN])     fsm_d = S_CHOICE1;
      end
      S_ACK: begin
        if (press_c[KENT] || press_c[KESC] || timeout_c) fsm_d = S_CHOICE2;
      end
      S_GAME: begin
        if (game_over)                              fsm_d = S_CHOICE1;
      end
      default:                                      fsm_d = S_CHOICE1;
    endcase
  end

  assign trans_c = (fsm_d != fsm_q);

  // Cursor blink: only runs in the two choice screens, a transition reloads it
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (trans_c || fsm_q == S_ACK || fsm_q == S_GAME) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q >= BLINK_FRAMES - 6'd1) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    state_d   = (fsm_d == S_GAME) ? 2'b00 : 2'(fsm_d);
    in_game_d = (fsm_d == S_GAME);
    start_d   = (fsm_q == S_CHOICE1) && (fsm_d == S_GAME);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_CHOICE1;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      state_q     <= 2'b00;
      in_game_q   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      state_q     <= state_d;
      in_game_q   <= in_game_d;
      start_q     <= start_d;
    end
  end

  assign state        = state_q;
  assign in_game      = in_game_q;
  assign start_game   = start_q;
  assign cursor_blink = blink_q;

endmodule

// File: tb/tb_welcome_menu_ctrl.sv
// Directed bench for welcome_menu_ctrl: vector table of key presses plus timing sequences.
module tb_welcome_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_up, key_down, key_enter, key_esc;
  logic       frame_tick, game_over;
  logic [1:0] state;
  logic       in_game, start_game, cursor_blink;

  int n_cmp = 0;
  int n_bad = 0;

  welcome_menu_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .BLINK_FRAMES   (6'd2),
    .ACK_FRAMES     (10'd3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_enter   (key_enter),
    .key_esc     (key_esc),
    .frame_tick  (frame_tick),
    .game_over   (game_over),
    .state       (state),
    .in_game     (in_game),
    .start_game  (start_game),
    .cursor_blink(cursor_blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] keys;      // {esc, enter, down, up}
    logic [1:0] exp_state;
    logic       exp_in_game;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_esc, key_enter, key_down, key_up} = k;
  endtask

  task automatic press(input logic [3:0] k);
    set_keys(k);
    tick(20);
    set_keys(4'b0000);
    tick(12);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_keys(4'b0000);
    frame_tick = 1'b0;
    game_over  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    tick(1);
  endtask

  logic [0:0] blink_exp [4];

  initial begin
    vecs[0]  = '{4'b0010, 2'b01, 1'b0};
    vecs[1]  = '{4'b0001, 2'b00, 1'b0};
    vecs[2]  = '{4'b0011, 2'b00, 1'b0};
    vecs[3]  = '{4'b0010, 2'b01, 1'b0};
    vecs[4]  = '{4'b0100, 2'b10, 1'b0};
    vecs[5]  = '{4'b0001, 2'b10, 1'b0};
    vecs[6]  = '{4'b0010, 2'b10, 1'b0};
    vecs[7]  = '{4'b1000, 2'b01, 1'b0};
    vecs[8]  = '{4'b1000, 2'b01, 1'b0};
    vecs[9]  = '{4'b0001, 2'b00, 1'b0};
    vecs[10] = '{4'b0110, 2'b00, 1'b1};
    vecs[11] = '{4'b0010, 2'b00, 1'b1};
    vecs[12] = '{4'b1000, 2'b00, 1'b1};
    blink_exp[0] = 1'b1;
    blink_exp[1] = 1'b0;
    blink_exp[2] = 1'b0;
    blink_exp[3] = 1'b1;

    do_reset();
    check("rst_state", 8'(state), 8'h00);
    check("rst_in_game", 8'(in_game), 8'h00);
    check("rst_start", 8'(start_game), 8'h00);
    check("rst_blink", 8'(cursor_blink), 8'h01);

    // Press latency: raw edge to state change takes 7 clocks
    key_down = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check($sformatf("lat_wait%0d", i), 8'(state), 8'h00);
    end
    tick(1);
    check("lat_change", 8'(state), 8'h01);
    tick(13);
    check("held_once", 8'(state), 8'h01);
    key_down = 1'b0;
    tick(12);
    check("release_no_evt", 8'(state), 8'h01);

    // Short glitch must not be accepted
    do_reset();
    key_up = 1'b1;
    tick(2);
    key_up = 1'b0;
    tick(15);
    check("glitch", 8'(state), 8'h00);

    // Vector table from CHOICE1
    do_reset();
    for (int i = 0; i < 13; i++) begin
      press(vecs[i].keys);
      check($sformatf("vec%0d_state", i), 8'(state), 8'(vecs[i].exp_state));
      check($sformatf("vec%0d_in_game", i), 8'(in_game), 8'(vecs[i].exp_in_game));
    end

    // ACK timeout behaviour
    do_reset();
    press(4'b0010);
    press(4'b0100);
    check("ack_entry", 8'(state), 8'h02);
    repeat (3) frame_pulse();
    tick(3);
`ifdef ACK_TIMEOUT_EN
    check("ack_timeout", 8'(state), 8'h01);
`else
    check("ack_timeout", 8'(state), 8'h02);
`endif

    // Game entry: one-cycle start pulse, keys ignored, game_over exits
    do_reset();
    key_enter = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check($sformatf("start_wait%0d", i), 8'(start_game), 8'h00);
    end
    tick(1);
    check("start_pulse", 8'(start_game), 8'h01);
    check("game_in_game", 8'(in_game), 8'h01);
    check("game_state", 8'(state), 8'h00);
    tick(1);
    check("start_one_cycle", 8'(start_game), 8'h00);
    key_enter = 1'b0;
    tick(12);
    press(4'b0010);
    check("game_ignore_keys", 8'(in_game), 8'h01);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    check("game_over_in_game", 8'(in_game), 8'h00);
    check("game_over_state", 8'(state), 8'h00);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    tick(1);
    check("stray_game_over", 8'(state), 8'h00);
    press(4'b0100);
    check("reenter_game", 8'(in_game), 8'h01);
    rst_n = 1'b0;
    #1;
    check("rst_mid_game_in_game", 8'(in_game), 8'h00);
    check("rst_mid_game_start", 8'(start_game), 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Cursor blink, reload on transition, reset mid-debounce
    do_reset();
    for (int i = 0; i < 4; i++) begin
      frame_pulse();
      check($sformatf("blink_tick%0d", i + 1), 8'(cursor_blink), 8'(blink_exp[i]));
    end
    frame_pulse();
    check("blink_tick5", 8'(cursor_blink), 8'h01);
    press(4'b0010);
    check("blink_move_state", 8'(state), 8'h01);
    check("blink_move", 8'(cursor_blink), 8'h01);
    frame_pulse();
    check("blink_reload1", 8'(cursor_blink), 8'h01);
    frame_pulse();
    check("blink_reload2", 8'(cursor_blink), 8'h00);
    key_up = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("rst_async_state", 8'(state), 8'h00);
    check("rst_async_blink", 8'(cursor_blink), 8'h01);
    check("rst_async_in_game", 8'(in_game), 8'h00);
    check("rst_async_start", 8'(start_game), 8'h00);
    key_up = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("post_rst_state", 8'(state), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
